// File: rtl/bcd_calc_sequencer_if.sv
// Keypad / ALU / display bundle for the BCD calculator sequencer.
// master = sequencer side, slave = keypad + ALU + display side.
interface bcd_calc_sequencer_if #(
  parameter int DIGIT_NUM = 8
);
  logic                   key_valid;
  logic [4:0]             key_code;
  logic                   key_ready;
  logic [4*DIGIT_NUM-1:0] operand0;
  logic                   operand0_sign;
  logic [4*DIGIT_NUM-1:0] operand1;
  logic                   operand1_sign;
  logic [2:0]             operation;
  logic                   op_valid;
  logic [4*DIGIT_NUM-1:0] result;
  logic                   result_sign;
  logic                   flag_ov;
  logic [4*DIGIT_NUM-1:0] display;
  logic                   display_sign;
  logic                   error;

  modport master (
    input  key_valid, key_code, result, result_sign, flag_ov,
    output key_ready, operand0, operand0_sign, operand1, operand1_sign,
           operation, op_valid, display, display_sign, error
  );

  modport slave (
    output key_valid, key_code, result, result_sign, flag_ov,
    input  key_ready, operand0, operand0_sign, operand1, operand1_sign,
           operation, op_valid, display, display_sign, error
  );
endinterface

// File: rtl/bcd_calc_sequencer.sv
// Keypad-driven operand/operator sequencer in front of a combinational BCD ALU.
// Optional macro CALC_BACKSPACE_EN enables key 18 (backspace) during operand entry.
module bcd_calc_sequencer #(
  parameter int DIGIT_NUM   = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_calc_sequencer_if.master bus
);
  localparam int W  = 4 * DIGIT_NUM;
  localparam int CW = $clog2(DIGIT_NUM + 1);

  typedef enum logic [2:0] {ENTER_A, OP_SEL, ENTER_B, EXEC, RESULT, ERROR} state_t;

  state_t        state_reg;
  logic [W-1:0]  op0_reg, op1_reg, res_reg, display_reg;
  logic          op0_sign_reg, op1_sign_reg, res_sign_reg, display_sign_reg, pend_sign_reg;
  logic [2:0]    operation_reg, next_op_reg;
  logic [CW-1:0] count_reg;
  logic [3:0]    lat_cnt_reg;
  logic          chain_reg, op_valid_reg, error_reg, key_ready_reg;

  logic          key_fire, is_digit, is_op, is_eq, is_clr, is_neg;
  logic [3:0]    key_digit;
  logic [2:0]    key_op;
  logic [W-1:0]  cur, cur_push, digit_only;
  logic          cur_sign, digit_ok, res_sign_eff;

  assign key_fire  = bus.key_valid && key_ready_reg;
  assign is_digit  = bus.key_code <= 5'd9;
  assign is_op     = (bus.key_code >= 5'd10) && (bus.key_code <= 5'd14);
  assign is_eq     = bus.key_code == 5'd15;
  assign is_clr    = bus.key_code == 5'd16;
  assign is_neg    = bus.key_code == 5'd17;
  assign key_digit = bus.key_code[3:0];
  assign key_op    = 3'(bus.key_code - 5'd10);

  // The entry being edited: operand1 in ENTER_B, operand0 otherwise.
  assign cur          = (state_reg == ENTER_B) ? op1_reg : op0_reg;
  assign cur_sign     = (state_reg == ENTER_B) ? op1_sign_reg : op0_sign_reg;
  assign cur_push     = {cur[W-5:0], key_digit};
  assign digit_only   = {{(W-4){1'b0}}, key_digit};
  assign digit_ok     = (count_reg != CW'(DIGIT_NUM)) && !((key_digit == 4'd0) && (cur == '0));
  assign res_sign_eff = bus.result_sign && (bus.result != '0);

`ifdef CALC_BACKSPACE_EN
  logic         is_bs;
  logic [W-1:0] cur_pop;
  assign is_bs   = bus.key_code == 5'd18;
  assign cur_pop = {4'h0, cur[W-1:4]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ENTER_A;
      op0_reg          <= '0;
      op1_reg          <= '0;
      res_reg          <= '0;
      display_reg      <= '0;
      op0_sign_reg     <= 1'b0;
      op1_sign_reg     <= 1'b0;
      res_sign_reg     <= 1'b0;
      display_sign_reg <= 1'b0;
      pend_sign_reg    <= 1'b0;
      operation_reg    <= 3'd0;
      next_op_reg      <= 3'd0;
      count_reg        <= '0;
      lat_cnt_reg      <= 4'd0;
      chain_reg        <= 1'b0;
      op_valid_reg     <= 1'b0;
      error_reg        <= 1'b0;
      key_ready_reg    <= 1'b1;
    end else if (key_fire && is_clr) begin
      state_reg        <= ENTER_A;
      op0_reg          <= '0;
      op1_reg          <= '0;
      res_reg          <= '0;
      display_reg      <= '0;
      op0_sign_reg     <= 1'b0;
      op1_sign_reg     <= 1'b0;
      res_sign_reg     <= 1'b0;
      display_sign_reg <= 1'b0;
      pend_sign_reg    <= 1'b0;
      operation_reg    <= 3'd0;
      next_op_reg      <= 3'd0;
      count_reg        <= '0;
      lat_cnt_reg      <= 4'd0;
      chain_reg        <= 1'b0;
      op_valid_reg     <= 1'b0;
      error_reg        <= 1'b0;
      key_ready_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ENTER_A, ENTER_B: if (key_fire) begin
          if (is_digit && digit_ok) begin
            if (state_reg == ENTER_A) op0_reg <= cur_push;
            else                      op1_reg <= cur_push;
            count_reg   <= count_reg + CW'(1);
            display_reg <= cur_push;
          end else if (is_neg && (cur != '0)) begin
            if (state_reg == ENTER_A) op0_sign_reg <= ~cur_sign;
            else                      op1_sign_reg <= ~cur_sign;
            display_sign_reg <= ~cur_sign;
          end else if (is_op && (state_reg == ENTER_A)) begin
            operation_reg <= key_op;
            pend_sign_reg <= 1'b0;
            state_reg     <= OP_SEL;
          end else if ((is_op || is_eq) && (state_reg == ENTER_B)) begin
            chain_reg     <= is_op;
            next_op_reg   <= key_op;
            op_valid_reg  <= 1'b1;
            key_ready_reg <= 1'b0;
            lat_cnt_reg   <= 4'(ALU_LATENCY);
            state_reg     <= EXEC;
          end
`ifdef CALC_BACKSPACE_EN
          else if (is_bs && (count_reg != '0)) begin
            if (state_reg == ENTER_A) op0_reg <= cur_pop;
            else                      op1_reg <= cur_pop;
            count_reg   <= count_reg - CW'(1);
            display_reg <= cur_pop;
            if (cur_pop == '0) begin
              if (state_reg == ENTER_A) op0_sign_reg <= 1'b0;
              else                      op1_sign_reg <= 1'b0;
              display_sign_reg <= 1'b0;
            end
          end
`endif
        end
        OP_SEL: if (key_fire) begin
          if (is_op) begin
            operation_reg <= key_op;
          end else if (is_digit) begin
            // First digit of B starts a fresh entry carrying any pre-typed sign.
            op1_reg          <= digit_only;
            op1_sign_reg     <= pend_sign_reg;
            count_reg        <= CW'(key_digit != 4'd0);
            display_reg      <= digit_only;
            display_sign_reg <= pend_sign_reg;
            state_reg        <= ENTER_B;
          end else if (is_neg) begin
            pend_sign_reg <= ~pend_sign_reg;
          end
        end
        EXEC: begin
          op_valid_reg <= 1'b0;
          if (lat_cnt_reg != 4'd0) begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end else begin
            key_ready_reg <= 1'b1;
            if (bus.flag_ov) begin
              error_reg        <= 1'b1;
              display_reg      <= '0;
              display_sign_reg <= 1'b0;
              state_reg        <= ERROR;
            end else begin
              res_reg          <= bus.result;
              res_sign_reg     <= res_sign_eff;
              display_reg      <= bus.result;
              display_sign_reg <= res_sign_eff;
              if (chain_reg) begin
                op0_reg       <= bus.result;
                op0_sign_reg  <= res_sign_eff;
                operation_reg <= next_op_reg;
                pend_sign_reg <= 1'b0;
                state_reg     <= OP_SEL;
              end else begin
                state_reg <= RESULT;
              end
            end
          end
        end
        RESULT: if (key_fire) begin
          if (is_digit) begin
            op0_reg          <= digit_only;
            op0_sign_reg     <= 1'b0;
            op1_reg          <= '0;
            op1_sign_reg     <= 1'b0;
            operation_reg    <= 3'd0;
            count_reg        <= CW'(key_digit != 4'd0);
            display_reg      <= digit_only;
            display_sign_reg <= 1'b0;
            state_reg        <= ENTER_A;
          end else if (is_op) begin
            op0_reg       <= res_reg;
            op0_sign_reg  <= res_sign_reg;
            operation_reg <= key_op;
            pend_sign_reg <= 1'b0;
            state_reg     <= OP_SEL;
          end else if (is_neg && (res_reg != '0)) begin
            res_sign_reg     <= ~res_sign_reg;
            display_sign_reg <= ~res_sign_reg;
          end
        end
        ERROR:   ;
        default: state_reg <= ENTER_A;
      endcase
    end
  end

  assign bus.key_ready     = key_ready_reg;
  assign bus.operand0      = op0_reg;
  assign bus.operand0_sign = op0_sign_reg;
  assign bus.operand1      = op1_reg;
  assign bus.operand1_sign = op1_sign_reg;
  assign bus.operation     = operation_reg;
  assign bus.op_valid      = op_valid_reg;
  assign bus.display       = display_reg;
  assign bus.display_sign  = display_sign_reg;
  assign bus.error         = error_reg;
endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Bench for bcd_calc_sequencer: decimal-arithmetic calculator model checked every cycle,
// plus hand-computed literal expectations. Honours CALC_BACKSPACE_EN like the design.
module tb_bcd_calc_sequencer;
  localparam int     DN      = 8;
  localparam int     ALU_LAT = 1;
  localparam int     W       = 4 * DN;
  localparam longint LIM     = 64'd100000000;
`ifdef CALC_BACKSPACE_EN
  localparam bit     BS_EN   = 1'b1;
`else
  localparam bit     BS_EN   = 1'b0;
`endif
  localparam int S_A = 0, S_OP = 1, S_B = 2, S_EX = 3, S_RES = 4, S_ERR = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic ov_force;
  bit   cmp_on;
  int   checks = 0;
  int   errors = 0;
  int   opv_cnt = 0;

  bcd_calc_sequencer_if #(.DIGIT_NUM(DN)) bus ();

  bcd_calc_sequencer #(.DIGIT_NUM(DN), .ALU_LATENCY(ALU_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DN; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint from_bcd(logic [W-1:0] b);
    longint v = 0;
    for (int i = DN - 1; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
    return v;
  endfunction

  // Signed decimal result; DIV/EXP are not exercised and read as overflow.
  function automatic longint alu_val(longint a, bit an, longint b, bit bn, logic [2:0] op);
    longint sa = an ? -a : a;
    longint sb = bn ? -b : b;
    case (op)
      3'd0:    return sa + sb;
      3'd1:    return sa - sb;
      3'd2:    return sa * sb;
      default: return LIM;
    endcase
  endfunction

  // ALU stand-in driven from the DUT's operand outputs.
  longint alu_r, alu_abs;
  always_comb begin
    alu_r   = alu_val(from_bcd(bus.operand0), bus.operand0_sign,
                      from_bcd(bus.operand1), bus.operand1_sign, bus.operation);
    alu_abs = (alu_r < 0) ? -alu_r : alu_r;
    bus.flag_ov     = (alu_abs >= LIM) || ov_force;
    bus.result      = (alu_abs >= LIM) ? '0 : to_bcd(alu_abs);
    bus.result_sign = alu_r < 0;
  end

  // ---------------- calculator model ----------------
  int         m_st, m_cnt, m_busy;
  longint     m_a, m_b, m_res, m_disp;
  bit         m_an, m_bn, m_resn, m_dispn, m_pend, m_err, m_ready, m_opv, m_chain;
  logic [2:0] m_op, m_next;

  task automatic m_reset();
    m_st = S_A; m_cnt = 0; m_busy = 0;
    m_a = 0; m_b = 0; m_res = 0; m_disp = 0;
    m_an = 0; m_bn = 0; m_resn = 0; m_dispn = 0; m_pend = 0;
    m_err = 0; m_ready = 1; m_opv = 0; m_chain = 0;
    m_op = 3'd0; m_next = 3'd0;
  endtask

  task automatic m_key(input int k);
    bit     dig, opk, was_a;
    longint v;
    bit     n;
    dig   = k <= 9;
    opk   = (k >= 10) && (k <= 14);
    was_a = m_st == S_A;
    if (k == 16) begin
      m_reset();
      return;
    end
    case (m_st)
      S_A, S_B: begin
        v = was_a ? m_a : m_b;
        n = was_a ? m_an : m_bn;
        if (dig) begin
          if (m_cnt < DN && !(k == 0 && v == 0)) begin
            v = v * 10 + k;
            m_cnt++;
          end
        end else if (k == 17) begin
          if (v != 0) n = !n;
        end else if (k == 18 && BS_EN) begin
          if (m_cnt > 0) begin
            v = v / 10;
            m_cnt--;
            if (v == 0) n = 0;
          end
        end else if (opk && was_a) begin
          m_op = 3'(k - 10); m_pend = 0; m_st = S_OP;
        end else if ((opk || k == 15) && !was_a) begin
          m_chain = opk; m_next = 3'(k - 10);
          m_st = S_EX; m_busy = ALU_LAT; m_opv = 1; m_ready = 0;
        end
        if (was_a) begin m_a = v; m_an = n; end
        else       begin m_b = v; m_bn = n; end
      end
      S_OP: begin
        if (opk) m_op = 3'(k - 10);
        else if (dig) begin
          m_b = k; m_bn = m_pend; m_cnt = (k != 0) ? 1 : 0; m_st = S_B;
        end else if (k == 17) m_pend = !m_pend;
      end
      S_RES: begin
        if (dig) begin
          m_reset();
          m_a = k; m_cnt = (k != 0) ? 1 : 0;
        end else if (opk) begin
          m_a = m_res; m_an = m_resn; m_op = 3'(k - 10); m_pend = 0; m_st = S_OP;
        end else if (k == 17) begin
          if (m_res != 0) m_resn = !m_resn;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    longint r, ra;
    if (!rst_n) begin
      m_reset();
    end else begin
      if (m_st == S_EX) begin
        m_opv = 0;
        if (m_busy == 0) begin
          r  = alu_val(m_a, m_an, m_b, m_bn, m_op);
          ra = (r < 0) ? -r : r;
          m_ready = 1;
          if (ra >= LIM || ov_force) begin
            m_st = S_ERR; m_err = 1;
          end else begin
            m_res = ra; m_resn = (r < 0);
            if (m_chain) begin
              m_a = ra; m_an = m_resn; m_op = m_next; m_pend = 0; m_st = S_OP;
            end else m_st = S_RES;
          end
        end else m_busy--;
      end else if (bus.key_valid && m_ready) begin
        m_key(int'(bus.key_code));
      end
      case (m_st)
        S_A, S_OP: begin m_disp = m_a;   m_dispn = m_an;   end
        S_B:       begin m_disp = m_b;   m_dispn = m_bn;   end
        S_RES:     begin m_disp = m_res; m_dispn = m_resn; end
        S_ERR:     begin m_disp = 0;     m_dispn = 0;      end
        default:   ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      chk("m_display",  64'(bus.display),       64'(to_bcd(m_disp)));
      chk("m_dsign",    64'(bus.display_sign),  64'(m_dispn));
      chk("m_error",    64'(bus.error),         64'(m_err));
      chk("m_keyready", 64'(bus.key_ready),     64'(m_ready));
      chk("m_opvalid",  64'(bus.op_valid),      64'(m_opv));
      chk("m_operand0", 64'(bus.operand0),      64'(to_bcd(m_a)));
      chk("m_op0sign",  64'(bus.operand0_sign), 64'(m_an));
      chk("m_operand1", 64'(bus.operand1),      64'(to_bcd(m_b)));
      chk("m_op1sign",  64'(bus.operand1_sign), 64'(m_bn));
      chk("m_operation",64'(bus.operation),     64'(m_op));
    end
  end

  always @(negedge clk) if (bus.op_valid) opv_cnt++;

  task automatic wait_idle();
    int n = 0;
    while (!bus.key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.key_ready) begin
      errors++;
      $display("FAIL key_ready_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic press(input int code);
    wait_idle();
    bus.key_valid = 1'b1;
    bus.key_code  = 5'(code);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    ov_force      = 1'b0;
    rst_n         = 1'b0;
    cmp_on        = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1; cmp_on = 1'b1;
    @(negedge clk);
    chk("rst_display",  64'(bus.display),   64'h0);
    chk("rst_keyready", 64'(bus.key_ready), 64'h1);
    chk("rst_error",    64'(bus.error),     64'h0);

    // 123 + 45
    press(1); press(2); press(3); press(10); press(4); press(5);
    opv_cnt = 0;
    press(15);
    chk("exec_busy", 64'(bus.key_ready), 64'h0);
    repeat (ALU_LAT + 1) @(negedge clk);
    chk("sum_display",  64'(bus.display),      64'h168);
    chk("sum_dsign",    64'(bus.display_sign), 64'h0);
    chk("sum_operand0", 64'(bus.operand0),     64'h123);
    chk("sum_operand1", 64'(bus.operand1),     64'h45);
    chk("sum_operation",64'(bus.operation),    64'h0);
    chk("sum_opv_count",64'(opv_cnt),          64'h1);

    // Negated result carried into the next calculation: -168 + 100
    press(17);
    chk("res_negate", 64'(bus.display_sign), 64'h1);
    press(10);
    chk("carry_op0", 64'(bus.operand0),      64'h168);
    chk("carry_sgn", 64'(bus.operand0_sign), 64'h1);
    press(1); press(0); press(0); press(15);
    wait_idle();
    chk("carry_display", 64'(bus.display),      64'h68);
    chk("carry_dsign",   64'(bus.display_sign), 64'h1);
    press(9);
    chk("res_digit_display", 64'(bus.display),  64'h9);
    chk("res_digit_op1",     64'(bus.operand1), 64'h0);

    // Digit limit and leading zeros
    press(16);
    for (int d = 1; d <= 9; d++) press(d);
    chk("nine_digits", 64'(bus.display), 64'h12345678);
    press(16); press(0); press(0); press(7); press(17);
    chk("lz_display", 64'(bus.display),      64'h7);
    chk("lz_dsign",   64'(bus.display_sign), 64'h1);
    for (int d = 1; d <= 8; d++) press(d);
    chk("lz_count", 64'(bus.display), 64'h71234567);

    // Chained operator: 5 - 8 = -3, then -3 + 2 = -1
    press(16); press(5); press(11); press(8); press(10);
    wait_idle();
    chk("chain_display",  64'(bus.display),       64'h3);
    chk("chain_dsign",    64'(bus.display_sign),  64'h1);
    chk("chain_op0sign",  64'(bus.operand0_sign), 64'h1);
    chk("chain_operation",64'(bus.operation),     64'h0);
    press(2); press(15);
    wait_idle();
    chk("chain2_display", 64'(bus.display),      64'h1);
    chk("chain2_dsign",   64'(bus.display_sign), 64'h1);

    // Natural overflow 99999999 + 1, then forced overflow
    press(16);
    repeat (8) press(9);
    press(10); press(1); press(15);
    wait_idle();
    chk("ov_error",   64'(bus.error),   64'h1);
    chk("ov_display", 64'(bus.display), 64'h0);
    press(5);
    chk("ov_digit_ignored", 64'(bus.display), 64'h0);
    press(16);
    chk("ov_clear", 64'(bus.error), 64'h0);
    press(3); press(10); press(4);
    ov_force = 1'b1;
    press(15);
    wait_idle();
    ov_force = 1'b0;
    chk("force_ov_error", 64'(bus.error), 64'h1);
    press(16); press(4);
    chk("after_clear_display", 64'(bus.display), 64'h4);

    // Key during EXEC is not consumed
    press(16); press(2); press(10); press(3);
    bus.key_valid = 1'b1; bus.key_code = 5'd15;
    @(negedge clk);
    bus.key_code = 5'd7;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("exec_key_ignored", 64'(bus.operand1), 64'h3);
    wait_idle();
    chk("exec_key_display", 64'(bus.display), 64'h5);

    // Asynchronous reset in the first EXEC cycle
    press(10); press(4);
    bus.key_valid = 1'b1; bus.key_code = 5'd15;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("exec_opvalid", 64'(bus.op_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_opvalid",  64'(bus.op_valid),  64'h0);
    chk("arst_operand0", 64'(bus.operand0),  64'h0);
    chk("arst_operand1", 64'(bus.operand1),  64'h0);
    chk("arst_display",  64'(bus.display),   64'h0);
    chk("arst_keyready", 64'(bus.key_ready), 64'h1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Backspace
    press(4); press(5); press(6); press(18);
    chk("bs_first", 64'(bus.display), BS_EN ? 64'h45 : 64'h456);
    press(18); press(18); press(18);
    chk("bs_empty", 64'(bus.display), BS_EN ? 64'h0 : 64'h456);
    press(16); press(3); press(17); press(18);
    chk("bs_sign", 64'(bus.display_sign), BS_EN ? 64'h0 : 64'h1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
